// File: rtl/train_phase_fsm_if.sv
// Control/status bundle between the training sequencer and the phase FSM.
interface train_phase_fsm_if #(
   parameter int CNT_W = 8,
   parameter int SEL_W = 2
);
   logic             start_fp;
   logic             start_bp;
   logic             wg_en;
   logic             abort;
   logic [1:0]       stride;
   logic [CNT_W-1:0] fp_len;
   logic [CNT_W-1:0] bp_len;
   logic [CNT_W-1:0] wg_len;
   logic [SEL_W-1:0] sel;
   logic             phase_en;
   logic             fp_done;
   logic             bp_done;
   logic             wg_done;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic [1:0]       curr_state;

   modport master (
      output start_fp, start_bp, wg_en, abort, stride, fp_len, bp_len, wg_len,
      input  sel, phase_en, fp_done, bp_done, wg_done, busy, count, curr_state
   );

   modport slave (
      input  start_fp, start_bp, wg_en, abort, stride, fp_len, bp_len, wg_len,
      output sel, phase_en, fp_done, bp_done, wg_done, busy, count, curr_state
   );
endinterface

// File: rtl/train_phase_fsm.sv
// Training phase sequencer: IDLE -> FP -> BP -> (optional) WG, each phase
// lasting len+1 cycles, with stride-select decode and per-phase done pulses.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start_fp / start_bp, counter held at 0
//   FP    | forward pass, may be preempted by start_bp
//   BP    | backward pass, continues to WG when wg_en was set at entry
//   WG    | weight-gradient pass, returns to IDLE
module train_phase_fsm #(
   parameter int CNT_W = 8,
   parameter int SEL_W = 2
) (
   input logic              clk,
   input logic              fsm_rst_n,
   train_phase_fsm_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FP   = 2'b01,
      ST_BP   = 2'b10,
      ST_WG   = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [1:0]       stride_q, stride_d;
   logic             wg_q, wg_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             fp_done_q, fp_done_d;
   logic             bp_done_q, bp_done_d;
   logic             wg_done_q, wg_done_d;
   logic             terminal;
   logic             entry;

   assign terminal = (count_q == len_q);

   // Stride-select decode for a given phase; stride 3 is reserved and maps to 00.
   function automatic logic [SEL_W-1:0] sel_decode(input state_t st, input logic [1:0] s);
      logic [1:0] v;
      v = 2'b00;
      if (st != ST_IDLE) begin
         case (s)
            2'd1:    v = (st == ST_BP) ? 2'b01 : 2'b11;
            2'd2:    v = 2'b10;
            default: v = 2'b00;
         endcase
      end
      return SEL_W'(v);
   endfunction

   // Next-state and done-pulse selection; abort overrides every transition.
   always_comb begin
      state_d   = state_q;
      fp_done_d = 1'b0;
      bp_done_d = 1'b0;
      wg_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_fp)      state_d = ST_FP;
            else if (bus.start_bp) state_d = ST_BP;
         end
         ST_FP: begin
            if (bus.start_bp) begin
               state_d   = ST_BP;
               fp_done_d = terminal;
            end else if (terminal) begin
               state_d   = ST_IDLE;
               fp_done_d = 1'b1;
            end
         end
         ST_BP: begin
            if (terminal) begin
               state_d   = wg_q ? ST_WG : ST_IDLE;
               bp_done_d = 1'b1;
            end
         end
         ST_WG: begin
            if (terminal) begin
               state_d   = ST_IDLE;
               wg_done_d = 1'b1;
            end
         end
      endcase
      if (bus.abort) begin
         state_d   = ST_IDLE;
         fp_done_d = 1'b0;
         bp_done_d = 1'b0;
         wg_done_d = 1'b0;
      end
   end

   // Counter and per-phase latches: reload on state change, else count to len.
   always_comb begin
      entry    = (state_d != state_q);
      count_d  = count_q;
      len_d    = len_q;
      stride_d = stride_q;
      wg_d     = wg_q;
      if (entry) begin
         count_d  = '0;
         stride_d = bus.stride;
         case (state_d)
            ST_FP:   len_d = bus.fp_len;
            ST_BP: begin
               len_d = bus.bp_len;
               wg_d  = bus.wg_en;
            end
            ST_WG:   len_d = bus.wg_len;
            default: len_d = '0;
         endcase
      end else if (state_q == ST_IDLE) begin
         count_d = '0;
      end else if (!terminal) begin
         count_d = count_q + CNT_W'(1);
      end
      sel_d = sel_decode(state_d, stride_d);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge fsm_rst_n) begin
      if (!fsm_rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         len_q     <= '0;
         stride_q  <= 2'b00;
         wg_q      <= 1'b0;
         sel_q     <= '0;
         fp_done_q <= 1'b0;
         bp_done_q <= 1'b0;
         wg_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         len_q     <= len_d;
         stride_q  <= stride_d;
         wg_q      <= wg_d;
         sel_q     <= sel_d;
         fp_done_q <= fp_done_d;
         bp_done_q <= bp_done_d;
         wg_done_q <= wg_done_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.count      = count_q;
   assign bus.curr_state = state_q;
   assign bus.phase_en   = (state_q != ST_IDLE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.fp_done    = fp_done_q;
   assign bus.bp_done    = bp_done_q;
   assign bus.wg_done    = wg_done_q;

endmodule

// File: tb/tb_train_phase_fsm.sv
// Bench for the training phase sequencer: directed scenarios followed by
// randomized traffic, all compared against a phase-level reference model.
module tb_train_phase_fsm;

   logic clk;
   logic rst_n;

   train_phase_fsm_if #(.CNT_W(8), .SEL_W(2)) bus ();

   train_phase_fsm #(.CNT_W(8), .SEL_W(2)) dut (
      .clk       (clk),
      .fsm_rst_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0=IDLE 1=FP 2=BP 3=WG, elapsed cycles in phase,
   // phase length latched at entry, stride and WG request latched at entry.
   int m_phase, m_cnt, m_len, m_stride, m_wg, m_sel;
   int m_fpd, m_bpd, m_wgd;
   int sel_lut [4][4] = '{'{0, 0, 0, 0}, '{0, 3, 2, 0}, '{0, 1, 2, 0}, '{0, 3, 2, 0}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_len = 0; m_stride = 0; m_wg = 0; m_sel = 0;
      m_fpd = 0; m_bpd = 0; m_wgd = 0;
   endtask

   task automatic model_step();
      int  np;
      int  term;
      np    = m_phase;
      term  = (m_cnt == m_len);
      m_fpd = 0; m_bpd = 0; m_wgd = 0;
      if (bus.abort) begin
         np = 0;
      end else begin
         case (m_phase)
            0: if (bus.start_fp) np = 1; else if (bus.start_bp) np = 2;
            1: begin
               if (bus.start_bp) begin np = 2; m_fpd = term; end
               else if (term != 0) begin np = 0; m_fpd = 1; end
            end
            2: if (term != 0) begin np = (m_wg != 0) ? 3 : 0; m_bpd = 1; end
            default: if (term != 0) begin np = 0; m_wgd = 1; end
         endcase
      end
      if (np != m_phase) begin
         m_cnt    = 0;
         m_stride = int'(bus.stride);
         case (np)
            1: m_len = int'(bus.fp_len);
            2: begin m_len = int'(bus.bp_len); m_wg = int'(bus.wg_en); end
            3: m_len = int'(bus.wg_len);
            default: m_len = 0;
         endcase
      end else if (np != 0 && term == 0) begin
         m_cnt++;
      end
      m_sel   = sel_lut[np][m_stride];
      m_phase = np;
   endtask

   task automatic check_all();
      chk("state",    32'(bus.curr_state), 32'(m_phase));
      chk("count",    32'(bus.count),      32'(m_cnt));
      chk("sel",      32'(bus.sel),        32'(m_sel));
      chk("phase_en", 32'(bus.phase_en),   32'(m_phase != 0));
      chk("busy",     32'(bus.busy),       32'(m_phase != 0));
      chk("fp_done",  32'(bus.fp_done),    32'(m_fpd));
      chk("bp_done",  32'(bus.bp_done),    32'(m_bpd));
      chk("wg_done",  32'(bus.wg_done),    32'(m_wgd));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic clear_inputs();
      bus.start_fp = 1'b0; bus.start_bp = 1'b0; bus.wg_en = 1'b0; bus.abort = 1'b0;
      bus.stride = 2'd0; bus.fp_len = 8'd0; bus.bp_len = 8'd0; bus.wg_len = 8'd0;
   endtask

   // Reset asserted between clock edges; outputs must clear before the next edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #2;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: FP with len 10, stride 1
      bus.fp_len = 8'd10; bus.stride = 2'd1; bus.start_fp = 1'b1;
      tick();
      bus.start_fp = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         chk("t1_cnt", 32'(bus.count), 32'(i));
         chk("t1_sel", 32'(bus.sel), 32'd3);
         tick();
      end
      chk("t1_idle", 32'(bus.curr_state), 32'd0);
      chk("t1_fp_done", 32'(bus.fp_done), 32'd1);
      tick();
      chk("t1_fp_done_low", 32'(bus.fp_done), 32'd0);

      // 2: start_fp wins over start_bp, then BP preempts FP at count 3
      bus.fp_len = 8'd20; bus.bp_len = 8'd6; bus.start_fp = 1'b1; bus.start_bp = 1'b1;
      tick();
      chk("t2_prio", 32'(bus.curr_state), 32'd1);
      bus.start_fp = 1'b0; bus.start_bp = 1'b0;
      repeat (3) tick();
      chk("t2_cnt3", 32'(bus.count), 32'd3);
      bus.start_bp = 1'b1;
      tick();
      bus.start_bp = 1'b0;
      chk("t2_bp", 32'(bus.curr_state), 32'd2);
      chk("t2_no_fp_done", 32'(bus.fp_done), 32'd0);
      chk("t2_cnt0", 32'(bus.count), 32'd0);
      chk("t2_sel", 32'(bus.sel), 32'd1);
      repeat (7) tick();
      chk("t2_bp_done", 32'(bus.bp_done), 32'd1);

      // 3: BP len 4 then WG len 2, stride 2
      bus.start_bp = 1'b1; bus.bp_len = 8'd4; bus.wg_en = 1'b1; bus.wg_len = 8'd2; bus.stride = 2'd2;
      tick();
      bus.start_bp = 1'b0; bus.wg_en = 1'b0;
      repeat (4) tick();
      chk("t3_bp_last", 32'(bus.count), 32'd4);
      tick();
      chk("t3_wg", 32'(bus.curr_state), 32'd3);
      chk("t3_bp_done", 32'(bus.bp_done), 32'd1);
      chk("t3_sel", 32'(bus.sel), 32'd2);
      repeat (2) tick();
      chk("t3_wg_busy", 32'(bus.wg_done), 32'd0);
      tick();
      chk("t3_wg_done", 32'(bus.wg_done), 32'd1);
      chk("t3_idle", 32'(bus.curr_state), 32'd0);
      tick();

      // 4: zero-length FP, then length latched at entry
      bus.fp_len = 8'd0; bus.start_fp = 1'b1;
      tick();
      bus.start_fp = 1'b0;
      tick();
      chk("t4_len0_done", 32'(bus.fp_done), 32'd1);
      bus.fp_len = 8'd5; bus.start_fp = 1'b1;
      tick();
      bus.start_fp = 1'b0; bus.fp_len = 8'd7;
      repeat (5) tick();
      chk("t4_still_fp", 32'(bus.curr_state), 32'd1);
      tick();
      chk("t4_done6", 32'(bus.fp_done), 32'd1);

      // 5: abort in BP and abort blocking start in IDLE
      bus.bp_len = 8'd8; bus.wg_en = 1'b1; bus.start_bp = 1'b1;
      tick();
      bus.start_bp = 1'b0;
      repeat (2) tick();
      bus.abort = 1'b1;
      tick();
      chk("t5_abort_idle", 32'(bus.curr_state), 32'd0);
      chk("t5_no_bp_done", 32'(bus.bp_done), 32'd0);
      bus.start_fp = 1'b1;
      tick();
      chk("t5_blocked", 32'(bus.curr_state), 32'd0);
      bus.abort = 1'b0; bus.start_fp = 1'b0;
      tick();

      // 6: async reset in WG, then normal restart
      bus.bp_len = 8'd1; bus.wg_len = 8'd9; bus.wg_en = 1'b1; bus.start_bp = 1'b1;
      tick();
      bus.start_bp = 1'b0;
      repeat (3) tick();
      chk("t6_in_wg", 32'(bus.curr_state), 32'd3);
      async_reset();
      bus.fp_len = 8'd2; bus.stride = 2'd2; bus.start_fp = 1'b1;
      tick();
      bus.start_fp = 1'b0;
      chk("t6_restart", 32'(bus.curr_state), 32'd1);
      chk("t6_sel", 32'(bus.sel), 32'd2);
      repeat (3) tick();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         bus.start_fp = ($urandom_range(0, 7) == 0);
         bus.start_bp = ($urandom_range(0, 9) == 0);
         bus.abort    = ($urandom_range(0, 39) == 0);
         bus.wg_en    = 1'($urandom_range(0, 1));
         bus.stride   = 2'($urandom_range(0, 3));
         bus.fp_len   = 8'($urandom_range(0, 12));
         bus.bp_len   = 8'($urandom_range(0, 12));
         bus.wg_len   = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 299) == 0) async_reset();
         else tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/train_phase_fsm.md
Name: train_phase_fsm

Overview:
- Parametrised successor to the FP/BP phase controller in the training datapath.
- Sequences IDLE → forward-pass (FP) → backward-pass (BP) → weight-gradient (WG) phases. Each phase runs for a programmable number of cycles.
- Drives the 2-bit stride-select mux, a phase-enable to the MAC array, and one-cycle done pulses per phase.
- WG is reachable and optional. Phase lengths and stride are latched per phase. A synchronous abort returns the block to IDLE.

Parameters:
- CNT_W, 8, width of phase counter and of the length inputs.
- SEL_W, 2, width of the stride-select output.

Ports:
- clk  in  1  clock.
- fsm_rst_n  in  1  asynchronous active-low reset.
- start_fp  in  1  request FP phase (level sampled in IDLE).
- start_bp  in  1  request BP phase (FC layer backward data ready).
- wg_en  in  1  run WG after BP (sampled on BP entry).
- abort  in  1  synchronous abort to IDLE.
- stride  in  2  stride mode, latched on phase entry.
- fp_len  in  CNT_W  FP terminal count; phase lasts fp_len+1 cycles.
- bp_len  in  CNT_W  BP terminal count.
- wg_len  in  CNT_W  WG terminal count.
- sel  out  SEL_W  stride-select to datapath mux.
- phase_en  out  1  high in any non-IDLE state.
- fp_done  out  1  one-cycle pulse, FP completed.
- bp_done  out  1  one-cycle pulse, BP completed.
- wg_done  out  1  one-cycle pulse, WG completed.
- busy  out  1  equals phase_en.
- count  out  CNT_W  current phase counter.
- curr_state  out  2  IDLE=00, FP=01, BP=10, WG=11.

Behaviour:
- Reset (async, fsm_rst_n=0): curr_state=IDLE, count=0, len_q=0, stride_q=0, wg_q=0, sel=0, all done pulses 0. Release is synchronous to clk.
- Entry: on every state entry, count←0, len_q←length of the new phase, stride_q←stride. wg_q←wg_en on BP entry only. Inputs changing mid-phase have no effect.
- Count: in a non-IDLE state, count increments each cycle while count≠len_q. Terminal = (count==len_q). Count is held at 0 in IDLE. A phase with len N lasts exactly N+1 cycles; len=0 gives a 1-cycle phase. There is no wrap: the counter never exceeds len_q.
- IDLE transitions: start_fp → FP. Otherwise start_bp → BP. Otherwise stay. start_fp has priority when both are high.
- FP transitions:
  - start_bp high at any cycle preempts FP: next state BP. fp_done is not pulsed unless that cycle was also terminal, in which case it is pulsed.
  - Else terminal → IDLE with fp_done.
  - Else stay.
- BP transitions: terminal → WG if wg_q, else IDLE. bp_done is pulsed in both cases.
- WG transitions: terminal → IDLE with wg_done.
- abort: has priority over everything in every state. Next state is IDLE, count←0, no done pulse. In IDLE, abort blocks start_fp/start_bp that cycle.
- Done pulses are registered: high for exactly the first cycle in the successor state, low otherwise.
- sel is a registered decode of (next state, stride at entry), so it is valid in the first cycle of the phase:
  - stride 0: 00 in all phases.
  - stride 1: FP 11, BP 01, WG 11.
  - stride 2: FP 10, BP 10, WG 10.
  - stride 3: reserved, 00.
  - IDLE: 00.
- phase_en/busy are combinational decodes of curr_state ≠ IDLE and carry no extra latency. Latency from start_fp sampled high to phase_en=1 is one clock.
- Mid-operation reset: immediate IDLE, outputs return to reset values asynchronously.

Test Plan:
1. Reset, fp_len=10, stride=1, pulse start_fp → FP for 11 cycles with sel=11 and count 0..10. Then IDLE with fp_done high for 1 cycle.
2. In IDLE, start_fp=1 and start_bp=1 together → FP entered. Then start_bp held high at FP count=3 → BP next cycle, no fp_done, count restarts at 0, sel=01.
3. start_bp, bp_len=4, wg_en=1, wg_len=2, stride=2 → BP for 5 cycles, bp_done pulse coinciding with the WG entry cycle, WG for 3 cycles with sel=10, then wg_done and IDLE.
4. fp_len=0 → 1-cycle FP, fp_done the next cycle. Change fp_len to 7 during a running FP with len 5 → phase still lasts 6 cycles.
5. abort at BP count=2 → IDLE next cycle, no bp_done, count=0, sel=00. abort together with start_fp in IDLE → stays IDLE.
6. Assert fsm_rst_n low mid-WG, asynchronously to clk → curr_state=00 and all outputs 0 before the next edge. After release, start_fp works normally.
